alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute datapath of the multi-cycle ARM-subset core, sitting between the register file and the write-back/PC logic.
- Latches register-file operands and selects the second operand (register or rotated immediate).
- Runs it through a 32-bit barrel shifter, then a 16-op ALU.
- Holds the result register F and the NZCV flag register, all under controller strobes.

Parameters:
- None. Fixed 32-bit datapath.

Ports:
- clk  in  1  single clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- r_data_a / r_data_b / r_data_c  in  32 each  register-file read data (rn / rm / rs).
- PC  in  32  current program counter.
- imm5  in  5  shift-amount immediate.
- imm12  in  12  rotate_imm[11:8] and imm8[7:0].
- imm24  in  24  branch offset.
- LA, LB, LC, LF  in  1 each  load strobes for A, B, C, F.
- ALU_A_s  in  1  ALU A select: 1 = PC, 0 = A.
- ALU_B_s  in  1  ALU B select: 1 = branch offset, 0 = shifter output.
- rm_imm_s_ctrl  in  1  shift data select: 1 = zero-extended imm12[7:0], 0 = B.
- rs_imm_s_ctrl  in  2  shift amount select: bit1 = rotate imm, else bit0 = C[7:0], else imm5.
- Shift_OP_ctrl  in  3  shifter op.
- ALU_OP_ctrl  in  4  ALU op.
- S_ctrl  in  1  update NZCV.
- F  out  32  result register.
- B_out  out  32  latched B (branch-to-register source).
- NZCV  out  4  flags; N=bit3, Z=bit2, C=bit1, V=bit0.

Behaviour:
- Reset (async, rst=1): A=B=C=F=0, NZCV=0. Reset has priority over every strobe.
- Falling clk edge, each independent:
  - LA: A<=r_data_a; LB: B<=r_data_b; LC: C<=r_data_c.
  - LF: F<=ALU result.
  - S_ctrl: NZCV<=ALU flags.
- Simultaneous LB and LF: the ALU uses the old B, because the shifter path is combinational from the registers.
- Shift amount:
  - rs_imm_s_ctrl[1]=1: 2*imm12[11:8], zero-extended to 8 bits.
  - else rs_imm_s_ctrl[0]=1: C[7:0].
  - else: zero-extended imm5.
- Branch offset: sign_extend(imm24) shifted left 2, 32 bits.
- Shifter op encoding: Shift_OP[2:1] = 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift_OP[0] = 1 register form (8-bit amount n), 0 immediate form.
- Shifter, carry-in Cin = NZCV[1]:
  - LSL: n=0 → data, carry Cin. n 1..31 → normal shift, carry = last bit out. n=32 → 0, carry data[0]. n>32 → 0, carry 0.
  - LSR: immediate n=0 means 32. n=32 → 0, carry data[31]. n>32 → 0, carry 0.
  - ASR: immediate n=0 means 32. n≥32 → all bits = data[31], carry data[31].
  - ROR register form: n=0 → data, carry Cin. n[4:0]=0 with n≠0 → data, carry data[31]. Otherwise rotate by n[4:0], carry = out[31].
  - ROR immediate form, n=0: see Optional Feature.
  - Rotated immediate operands use ROR register form.
- ALU ops, with A'/B' the selected inputs and c=NZCV[1]:
  - Logical: 0 AND, 1 EOR, 8 TST (AND), 9 TEQ (EOR), C ORR, D MOV (B'), E BIC (A'&~B'), F MVN (~B').
  - Arithmetic: 2 SUB A'-B', 3 RSB B'-A', 4 ADD, 5 ADC A'+B'+c, 6 SBC A'+~B'+c, 7 RSC B'+~A'+c, A CMP (SUB), B CMN (ADD).
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = 33rd-bit carry (subtract: 1 = no borrow); V = signed overflow.
  - Logical ops: C = shifter carry; V unchanged.
- TST/TEQ/CMP/CMN still produce a result. F loads it if LF is asserted; the controller normally deasserts LF for these ops.

Optional Feature:
- Macro: EXEC_RRX_EN.
- Defined: ROR immediate with n=0 is RRX, giving {Cin, data[31:1]} with carry data[0].
- Undefined: ROR immediate with n=0 passes data unchanged with carry Cin; no RRX support.

Test Plan:
- rst=1 mid-run with LF/S_ctrl active → F=0, NZCV=0 immediately; nothing loads while rst is held.
- A=0x7FFFFFFF, B=1, LSL imm #0, ALU ADD, S=1 → F=0x80000000, NZCV=1001.
- A=5, B=5, CMP, S=1, LF=0 → F unchanged, NZCV=0110 (Z=1, C=1).
- rm_imm_s=1, imm12=0x4FF, rs_imm_s=10, ROR register form, MOV → F=0xFF000000; C=1 on a logical op with S=1.
- B=0x80000000, ASR register form, C[7:0]=40 → F=0xFFFFFFFF, C=1. LSR register form, amount 33 → F=0, C=0.
- ALU_A_s=1, PC=0x100, ALU_B_s=1, imm24=0xFFFFFE, ADD → F=0xF8. With EXEC_RRX_EN: B=3, Cin=1, ROR imm #0 → 0x80000001, C=1; without the macro → 3, C=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute datapath: operand latches, barrel shifter, 16-op ALU, F and NZCV.
// Optional macro EXEC_RRX_EN: ROR immediate #0 performs RRX.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] r_data_a,
    input  logic [31:0] r_data_b,
    input  logic [31:0] r_data_c,
    input  logic [31:0] PC,
    input  logic [4:0]  imm5,
    input  logic [11:0] imm12,
    input  logic [23:0] imm24,
    input  logic        LA,
    input  logic        LB,
    input  logic        LC,
    input  logic        LF,
    input  logic        ALU_A_s,
    input  logic        ALU_B_s,
    input  logic        rm_imm_s_ctrl,
    input  logic [1:0]  rs_imm_s_ctrl,
    input  logic [2:0]  Shift_OP_ctrl,
    input  logic [3:0]  ALU_OP_ctrl,
    input  logic        S_ctrl,
    output logic [31:0] F,
    output logic [31:0] B_out,
    output logic [3:0]  NZCV
);

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] c_q;
    logic        cin;

    logic [31:0] sh_data;
    logic [7:0]  sh_amt;
    logic [4:0]  s;
    logic [31:0] br_off;
    logic [32:0] lsl33;
    logic [32:0] rsh33;
    logic [32:0] asr33;
    logic [31:0] rot_v;
    logic [31:0] sh_out;
    logic        sh_c;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_ci;
    logic        arith;
    logic [31:0] log_res;
    logic [32:0] sum;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;

    // Only the low byte of C is ever used as a shift amount.
    logic unused_c;
    assign unused_c = ^c_q[31:8];

    assign B_out = b_q;
    assign cin   = NZCV[1];

    assign br_off = {{6{imm24[23]}}, imm24, 2'b00};
    assign s      = sh_amt[4:0];
    assign lsl33  = {1'b0, sh_data} << s;
    assign rsh33  = {sh_data, 1'b0} >> s;
    assign asr33  = $signed({sh_data, 1'b0}) >>> s;
    assign rot_v  = (sh_data >> s) | (sh_data << (6'd32 - {1'b0, s}));

    // Shifter data and amount selection.
    always_comb begin
        sh_data = rm_imm_s_ctrl ? {24'd0, imm12[7:0]} : b_q;
        if (rs_imm_s_ctrl[1])
            sh_amt = {3'd0, imm12[11:8], 1'b0};
        else if (rs_imm_s_ctrl[0])
            sh_amt = c_q[7:0];
        else
            sh_amt = {3'd0, imm5};
    end

    // Barrel shifter with ARM-style carry-out.
    always_comb begin
        sh_out = sh_data;
        sh_c   = cin;
        case (Shift_OP_ctrl[2:1])
            2'b00: begin
                if (sh_amt == 8'd0) begin
                    sh_out = sh_data;
                end else if (sh_amt < 8'd32) begin
                    {sh_c, sh_out} = lsl33;
                end else if (sh_amt == 8'd32) begin
                    sh_out = 32'd0;
                    sh_c   = sh_data[0];
                end else begin
                    sh_out = 32'd0;
                    sh_c   = 1'b0;
                end
            end
            2'b01: begin
                if (sh_amt == 8'd0) begin
                    if (!Shift_OP_ctrl[0]) begin
                        sh_out = 32'd0;
                        sh_c   = sh_data[31];
                    end
                end else if (sh_amt < 8'd32) begin
                    {sh_out, sh_c} = rsh33;
                end else if (sh_amt == 8'd32) begin
                    sh_out = 32'd0;
                    sh_c   = sh_data[31];
                end else begin
                    sh_out = 32'd0;
                    sh_c   = 1'b0;
                end
            end
            2'b10: begin
                if (sh_amt == 8'd0 && Shift_OP_ctrl[0]) begin
                    sh_out = sh_data;
                end else if (sh_amt != 8'd0 && sh_amt < 8'd32) begin
                    {sh_out, sh_c} = asr33;
                end else begin
                    sh_out = {32{sh_data[31]}};
                    sh_c   = sh_data[31];
                end
            end
            default: begin
                if (sh_amt == 8'd0) begin
`ifdef EXEC_RRX_EN
                    if (!Shift_OP_ctrl[0]) begin
                        sh_out = {cin, sh_data[31:1]};
                        sh_c   = sh_data[0];
                    end
`endif
                end else begin
                    sh_out = rot_v;
                    sh_c   = rot_v[31];
                end
            end
        endcase
    end

    // ALU operand select, operation decode and flag generation.
    always_comb begin
        alu_a   = ALU_A_s ? PC : a_q;
        alu_b   = ALU_B_s ? br_off : sh_out;
        add_x   = alu_a;
        add_y   = alu_b;
        add_ci  = 1'b0;
        arith   = 1'b1;
        log_res = 32'd0;
        unique case (ALU_OP_ctrl)
            4'h0, 4'h8: begin
                arith   = 1'b0;
                log_res = alu_a & alu_b;
            end
            4'h1, 4'h9: begin
                arith   = 1'b0;
                log_res = alu_a ^ alu_b;
            end
            4'hC: begin
                arith   = 1'b0;
                log_res = alu_a | alu_b;
            end
            4'hD: begin
                arith   = 1'b0;
                log_res = alu_b;
            end
            4'hE: begin
                arith   = 1'b0;
                log_res = alu_a & ~alu_b;
            end
            4'hF: begin
                arith   = 1'b0;
                log_res = ~alu_b;
            end
            4'h2, 4'hA: begin
                add_y  = ~alu_b;
                add_ci = 1'b1;
            end
            4'h3: begin
                add_x  = alu_b;
                add_y  = ~alu_a;
                add_ci = 1'b1;
            end
            4'h4, 4'hB: begin
                add_ci = 1'b0;
            end
            4'h5: begin
                add_ci = cin;
            end
            4'h6: begin
                add_y  = ~alu_b;
                add_ci = cin;
            end
            4'h7: begin
                add_x  = alu_b;
                add_y  = ~alu_a;
                add_ci = cin;
            end
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_ci};
        if (arith) begin
            alu_res      = sum[31:0];
            alu_flags[1] = sum[32];
            alu_flags[0] = (add_x[31] == add_y[31]) &&
                           (sum[31] != add_x[31]);
        end else begin
            alu_res      = log_res;
            alu_flags[1] = sh_c;
            alu_flags[0] = NZCV[0];
        end
        alu_flags[3] = alu_res[31];
        alu_flags[2] = (alu_res == 32'd0);
    end

    // State registers update on the falling edge under controller strobes.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            c_q  <= 32'd0;
            F    <= 32'd0;
            NZCV <= 4'd0;
        end else begin
            if (LA) a_q <= r_data_a;
            if (LB) b_q <= r_data_b;
            if (LC) c_q <= r_data_c;
            if (LF) F <= alu_res;
            if (S_ctrl) NZCV <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboarded random and directed bench for alu_exec_unit.
// Reference model computes shifts and flags arithmetically.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] ra, rb, rc, pc;
        logic [4:0]  imm5;
        logic [11:0] imm12;
        logic [23:0] imm24;
        logic        la, lb, lc, lf, as, bs, rm, s;
        logic [1:0]  rs;
        logic [2:0]  sop;
        logic [3:0]  aop;
    } op_t;

    typedef struct {
        logic [31:0] f;
        logic [31:0] b;
        logic [3:0]  nzcv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] r_data_a = '0, r_data_b = '0, r_data_c = '0, PC = '0;
    logic [4:0]  imm5 = '0;
    logic [11:0] imm12 = '0;
    logic [23:0] imm24 = '0;
    logic        LA = 0, LB = 0, LC = 0, LF = 0;
    logic        ALU_A_s = 0, ALU_B_s = 0, rm_imm_s_ctrl = 0, S_ctrl = 0;
    logic [1:0]  rs_imm_s_ctrl = '0;
    logic [2:0]  Shift_OP_ctrl = '0;
    logic [3:0]  ALU_OP_ctrl = '0;
    logic [31:0] F, B_out;
    logic [3:0]  NZCV;

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];

    logic [31:0] m_a = 0, m_b = 0, m_c = 0, m_f = 0;
    logic [3:0]  m_nzcv = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst(rst),
        .r_data_a(r_data_a), .r_data_b(r_data_b), .r_data_c(r_data_c),
        .PC(PC), .imm5(imm5), .imm12(imm12), .imm24(imm24),
        .LA(LA), .LB(LB), .LC(LC), .LF(LF),
        .ALU_A_s(ALU_A_s), .ALU_B_s(ALU_B_s),
        .rm_imm_s_ctrl(rm_imm_s_ctrl), .rs_imm_s_ctrl(rs_imm_s_ctrl),
        .Shift_OP_ctrl(Shift_OP_ctrl), .ALU_OP_ctrl(ALU_OP_ctrl),
        .S_ctrl(S_ctrl), .F(F), .B_out(B_out), .NZCV(NZCV)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Shift one bit at a time; carry is the last bit moved out.
    function automatic logic [32:0] m_shift(logic [31:0] d, logic [7:0] n,
                                            logic [2:0] op, logic cin);
        int k = int'(n);
        logic c = cin;
        case (op[2:1])
            2'b00: for (int i = 0; i < k; i++) begin
                c = d[31];
                d = d << 1;
            end
            2'b01: begin
                if (!op[0] && k == 0) k = 32;
                for (int i = 0; i < k; i++) begin
                    c = d[0];
                    d = d >> 1;
                end
            end
            2'b10: begin
                if (!op[0] && k == 0) k = 32;
                for (int i = 0; i < k; i++) begin
                    c = d[0];
                    d = {d[31], d[31:1]};
                end
            end
            default: begin
                if (k == 0) begin
`ifdef EXEC_RRX_EN
                    if (!op[0]) begin
                        c = d[0];
                        d = {cin, d[31:1]};
                    end
`endif
                end else begin
                    for (int i = 0; i < k % 32; i++) d = {d[0], d[31:1]};
                    c = d[31];
                end
            end
        endcase
        return {c, d};
    endfunction

    function automatic void m_eval(op_t o, output logic [31:0] res,
                                   output logic [3:0] fl);
        logic [31:0] sd, a, b;
        logic [7:0]  amt;
        logic [32:0] sh;
        logic        c, v, cin, arith, is_sub;
        longint      ua, ub, sa, sbv, ur, sr;
        cin = m_nzcv[1];
        sd  = o.rm ? {24'd0, o.imm12[7:0]} : m_b;
        if (o.rs[1]) amt = 8'(int'(o.imm12[11:8]) * 2);
        else if (o.rs[0]) amt = m_c[7:0];
        else amt = {3'd0, o.imm5};
        sh = m_shift(sd, amt, o.sop, cin);
        a  = o.as ? o.pc : m_a;
        b  = o.bs ? 32'($signed(o.imm24) * 4) : sh[31:0];
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        arith = 1; is_sub = 1; ur = 0; sr = 0; res = 0;
        case (o.aop)
            4'h2, 4'hA: begin ur = ua - ub; sr = sa - sbv; end
            4'h3: begin ur = ub - ua; sr = sbv - sa; end
            4'h4, 4'hB: begin ur = ua + ub; sr = sa + sbv; is_sub = 0; end
            4'h5: begin
                ur = ua + ub + cin; sr = sa + sbv + cin; is_sub = 0;
            end
            4'h6: begin ur = ua - ub - (1 - cin); sr = sa - sbv - (1 - cin); end
            4'h7: begin ur = ub - ua - (1 - cin); sr = sbv - sa - (1 - cin); end
            4'h0, 4'h8: begin arith = 0; res = a & b; end
            4'h1, 4'h9: begin arith = 0; res = a ^ b; end
            4'hC: begin arith = 0; res = a | b; end
            4'hD: begin arith = 0; res = b; end
            4'hE: begin arith = 0; res = a & ~b; end
            default: begin arith = 0; res = ~b; end
        endcase
        if (arith) begin
            res = ur[31:0];
            c = is_sub ? (ur >= 0) : (ur > 64'sh0_FFFF_FFFF);
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else begin
            c = sh[32];
            v = m_nzcv[0];
        end
        fl = {res[31], res == 32'd0, c, v};
    endfunction

    task automatic issue(op_t o);
        logic [31:0] res;
        logic [3:0]  fl;
        exp_t e;
        @(posedge clk);
        #2;
        r_data_a = o.ra; r_data_b = o.rb; r_data_c = o.rc; PC = o.pc;
        imm5 = o.imm5; imm12 = o.imm12; imm24 = o.imm24;
        LA = o.la; LB = o.lb; LC = o.lc; LF = o.lf; S_ctrl = o.s;
        ALU_A_s = o.as; ALU_B_s = o.bs; rm_imm_s_ctrl = o.rm;
        rs_imm_s_ctrl = o.rs; Shift_OP_ctrl = o.sop; ALU_OP_ctrl = o.aop;
        m_eval(o, res, fl);
        @(negedge clk);
        #1;
        if (o.lf) m_f = res;
        if (o.s) m_nzcv = fl;
        if (o.la) m_a = o.ra;
        if (o.lb) m_b = o.rb;
        if (o.lc) m_c = o.rc;
        e.f = m_f; e.b = m_b; e.nzcv = m_nzcv;
        sb.push_back(e);
    endtask

    function automatic op_t nop();
        op_t o;
        o.ra = 0; o.rb = 0; o.rc = 0; o.pc = 0;
        o.imm5 = 0; o.imm12 = 0; o.imm24 = 0;
        o.la = 0; o.lb = 0; o.lc = 0; o.lf = 0;
        o.as = 0; o.bs = 0; o.rm = 0; o.s = 0;
        o.rs = 0; o.sop = 0; o.aop = 4'hD;
        return o;
    endfunction

    function automatic op_t ld(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                               logic la, logic lb, logic lc);
        op_t o = nop();
        o.ra = a; o.rb = b; o.rc = c; o.la = la; o.lb = lb; o.lc = lc;
        return o;
    endfunction

    // Monitor: compare outputs against the oldest expected entry.
    always @(posedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_F", F, e.f);
            chk("sb_B_out", B_out, e.b);
            chk("sb_NZCV", {28'd0, NZCV}, {28'd0, e.nzcv});
        end
    end

    initial begin
        op_t o;
        rst = 1'b1;
        #12;
        chk("reset_F", F, 32'd0);
        chk("reset_NZCV", {28'd0, NZCV}, 32'd0);
        chk("reset_B", B_out, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        issue(ld(32'h7FFF_FFFF, 32'd1, 0, 1, 1, 0));
        o = nop(); o.aop = 4'h4; o.lf = 1; o.s = 1;
        issue(o);
        chk("add_ovf_F", F, 32'h8000_0000);
        chk("add_ovf_NZCV", {28'd0, NZCV}, 32'h9);

        issue(ld(32'd5, 32'd5, 0, 1, 1, 0));
        o = nop(); o.aop = 4'hA; o.s = 1;
        issue(o);
        chk("cmp_F_kept", F, 32'h8000_0000);
        chk("cmp_NZCV", {28'd0, NZCV}, 32'h6);

        o = nop(); o.rm = 1; o.imm12 = 12'h4FF; o.rs = 2'b10;
        o.sop = 3'b111; o.lf = 1; o.s = 1;
        issue(o);
        chk("rotimm_F", F, 32'hFF00_0000);
        chk("rotimm_NZCV", {28'd0, NZCV}, 32'hA);

        issue(ld(0, 32'h8000_0000, 32'd40, 0, 1, 1));
        o = nop(); o.rs = 2'b01; o.sop = 3'b101; o.lf = 1; o.s = 1;
        issue(o);
        chk("asr40_F", F, 32'hFFFF_FFFF);
        chk("asr40_C", {31'd0, NZCV[1]}, 32'd1);

        issue(ld(0, 0, 32'd33, 0, 0, 1));
        o = nop(); o.rs = 2'b01; o.sop = 3'b011; o.lf = 1; o.s = 1;
        issue(o);
        chk("lsr33_F", F, 32'd0);
        chk("lsr33_C", {31'd0, NZCV[1]}, 32'd0);

        o = nop(); o.as = 1; o.pc = 32'h100; o.bs = 1;
        o.imm24 = 24'hFFFFFE; o.aop = 4'h4; o.lf = 1;
        issue(o);
        chk("branch_F", F, 32'hF8);

        issue(ld(32'd5, 32'd5, 0, 1, 1, 0));
        o = nop(); o.aop = 4'hA; o.s = 1;
        issue(o);
        issue(ld(0, 32'd3, 0, 0, 1, 0));
        o = nop(); o.sop = 3'b110; o.lf = 1; o.s = 1;
        issue(o);
`ifdef EXEC_RRX_EN
        chk("ror0_F", F, 32'h8000_0001);
`else
        chk("ror0_F", F, 32'd3);
`endif
        chk("ror0_C", {31'd0, NZCV[1]}, 32'd1);

        issue(ld(0, 32'h1234, 0, 0, 1, 0));
        o = nop(); o.rb = 32'hDEAD; o.lb = 1; o.lf = 1;
        issue(o);
        chk("lb_lf_oldB", F, 32'h1234);
        chk("lb_lf_newB", B_out, 32'hDEAD);

        for (int i = 0; i < 400; i++) begin
            o.ra = $urandom; o.rb = $urandom; o.pc = $urandom;
            o.rc = ($urandom_range(0, 3) == 0) ? $urandom
                                                : $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) o.rb = $urandom_range(0, 3);
            o.imm5 = 5'($urandom); o.imm12 = 12'($urandom);
            o.imm24 = 24'($urandom);
            o.la = 1'($urandom); o.lb = 1'($urandom); o.lc = 1'($urandom);
            o.lf = 1'($urandom); o.s = 1'($urandom);
            o.as = ($urandom_range(0, 5) == 0);
            o.bs = ($urandom_range(0, 5) == 0);
            o.rm = 1'($urandom); o.rs = 2'($urandom);
            o.sop = 3'($urandom); o.aop = 4'($urandom);
            issue(o);
        end

        @(posedge clk);
        #2;
        LF = 1; S_ctrl = 1; LA = 1; LB = 1; LC = 1;
        r_data_b = 32'hFFFF_FFFF; ALU_OP_ctrl = 4'hF;
        rst = 1'b1;
        #1;
        chk("midrst_F", F, 32'd0);
        chk("midrst_NZCV", {28'd0, NZCV}, 32'd0);
        @(negedge clk);
        #1;
        chk("rsthold_F", F, 32'd0);
        chk("rsthold_NZCV", {28'd0, NZCV}, 32'd0);
        chk("rsthold_B", B_out, 32'd0);
        LF = 0; S_ctrl = 0; LA = 0; LB = 0; LC = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_f = 0; m_nzcv = 0;

        issue(ld(32'hFFFF_FFFF, 32'd1, 0, 1, 1, 0));
        o = nop(); o.aop = 4'h4; o.lf = 1; o.s = 1;
        issue(o);
        chk("post_rst_add_F", F, 32'd0);
        chk("post_rst_add_NZCV", {28'd0, NZCV}, 32'h6);

        @(posedge clk);
        #2;
        LA = 0; LB = 0; LC = 0; LF = 0; S_ctrl = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
